// File: rtl/pwm_status_poller.sv
// Periodic Avalon-MM status poller: reads one register every POLL_PERIOD idle cycles,
// latches the low WIDTH bits, tracks sticky bit changes and raises a masked interrupt.
module pwm_status_poller #(
    parameter int             POLL_PERIOD  = 1000,
    parameter logic [3:0]     POLL_ADDRESS = 4'd0,
    parameter int             TIMEOUT      = 16,
    parameter int             WIDTH        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [3:0]       avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic             avm_readdatavalid,
    input  logic [31:0]      avm_readdata,
    output logic [WIDTH-1:0] status,
    output logic             status_valid,
    output logic [WIDTH-1:0] edge_capture,
    input  logic             edge_clear,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq,
    output logic             timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [15:0] PERIOD_LOAD  = 16'(POLL_PERIOD - 1);
    localparam logic [7:0]  TIMEOUT_LOAD = 8'(TIMEOUT);

    state_t            state, state_next;
    logic [15:0]       period_cnt;
    logic [7:0]        timeout_cnt;
    logic              poll_ok, poll_fail;
    logic [WIDTH-1:0]  new_bits, changed;
    logic              unused_bits;

    assign avm_address = POLL_ADDRESS;
    assign new_bits    = avm_readdata[WIDTH-1:0];
    assign changed     = status ^ new_bits;
    assign unused_bits = &{1'b0, avm_readdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            avm_read <= 1'b0;
        end else begin
            state    <= state_next;
            avm_read <= (state_next == REQ);
        end
    end

    // Readdatavalid only matters in WAIT, so stray strobes elsewhere fall out naturally.
    always_comb begin
        state_next = state;
        poll_ok    = 1'b0;
        poll_fail  = 1'b0;
        case (state)
            IDLE: if (enable && period_cnt == 16'd0) state_next = REQ;
            REQ:  if (!avm_waitrequest) state_next = WAIT;
            WAIT: begin
                if (avm_readdatavalid) begin
                    poll_ok    = 1'b1;
                    state_next = IDLE;
                end else if (timeout_cnt <= 8'd1) begin
                    poll_fail  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt  <= PERIOD_LOAD;
            timeout_cnt <= 8'd0;
        end else begin
            if (state != IDLE && state_next == IDLE)
                period_cnt <= PERIOD_LOAD;
            else if (state == IDLE && enable && period_cnt != 16'd0)
                period_cnt <= period_cnt - 16'd1;

            if (state == REQ && state_next == WAIT)
                timeout_cnt <= TIMEOUT_LOAD;
            else if (state == WAIT && timeout_cnt != 8'd0)
                timeout_cnt <= timeout_cnt - 8'd1;
        end
    end

    // Fresh change bits and a new timeout both win over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status       <= '0;
            status_valid <= 1'b0;
            edge_capture <= '0;
            timeout_err  <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (poll_ok) begin
                status       <= new_bits;
                status_valid <= 1'b1;
                edge_capture <= (edge_clear ? '0 : edge_capture) |
                                (status_valid ? changed : '0);
            end else if (edge_clear) begin
                edge_capture <= '0;
            end

            if (poll_fail)
                timeout_err <= 1'b1;
            else if (edge_clear)
                timeout_err <= 1'b0;

            irq <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_pwm_status_poller.sv
// Self-checking bench for pwm_status_poller: vector table of polls plus hand-written
// sequences for waitrequest stall, timeout, enable drop and reset mid-transaction.
module tb_pwm_status_poller;

    localparam int         PP   = 4;
    localparam logic [3:0] ADDR = 4'hA;
    localparam int         TO   = 16;
    localparam int         W    = 8;

    logic         clk = 1'b0;
    logic         reset, enable, avm_read, avm_waitrequest, avm_readdatavalid;
    logic         status_valid, edge_clear, irq, timeout_err;
    logic [3:0]   avm_address;
    logic [31:0]  avm_readdata;
    logic [W-1:0] status, edge_capture, irq_mask;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        int         nwait;
        logic       clr_before;
        logic       clr_with;
        logic [7:0] mask;
        logic [7:0] prior;
        logic [7:0] exp_status;
        logic [7:0] exp_edge;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    pwm_status_poller #(
        .POLL_PERIOD(PP), .POLL_ADDRESS(ADDR), .TIMEOUT(TO), .WIDTH(W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata), .status(status), .status_valid(status_valid),
        .edge_capture(edge_capture), .edge_clear(edge_clear), .irq_mask(irq_mask),
        .irq(irq), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_read();
        int n = 0;
        while (!avm_read && n < 100) begin
            tick();
            n++;
        end
        chk("read_issued", 32'(avm_read), 32'd1);
    endtask

    // Serve one poll: stall nwait cycles, accept, return data one cycle later.
    task automatic poll(input logic [7:0] data, input int nwait, input logic clr_with,
                        input logic [7:0] exp);
        int reads = 1;
        wait_read();
        avm_waitrequest = (nwait > 0);
        for (int i = 0; i < nwait; i++) begin
            tick();
            if (avm_read) reads++;
            chk("avm_address", 32'(avm_address), 32'(ADDR));
        end
        avm_waitrequest = 1'b0;
        tick();
        chk("read_cycles", reads, nwait + 1);
        chk("read_dropped", 32'(avm_read), 32'd0);
        sb_q.push_back(exp);
        avm_readdata      = {24'h0, data};
        avm_readdatavalid = 1'b1;
        edge_clear        = clr_with;
        tick();
        avm_readdatavalid = 1'b0;
        edge_clear        = 1'b0;
        chk("status", 32'(status), 32'(sb_q.pop_front()));
        chk("status_valid", 32'(status_valid), 32'd1);
    endtask

    initial begin
        int   n;
        logic flag;

        vecs[0] = '{data:8'h5A, nwait:0, clr_before:0, clr_with:0, mask:8'h01, prior:8'h00,
                    exp_status:8'h5A, exp_edge:8'h00, exp_irq:0};
        vecs[1] = '{data:8'h5B, nwait:3, clr_before:0, clr_with:0, mask:8'h01, prior:8'h00,
                    exp_status:8'h5B, exp_edge:8'h01, exp_irq:1};
        vecs[2] = '{data:8'h01, nwait:0, clr_before:1, clr_with:0, mask:8'hFF, prior:8'h00,
                    exp_status:8'h01, exp_edge:8'h5A, exp_irq:1};
        vecs[3] = '{data:8'h00, nwait:1, clr_before:1, clr_with:0, mask:8'h01, prior:8'h00,
                    exp_status:8'h00, exp_edge:8'h01, exp_irq:1};
        vecs[4] = '{data:8'h08, nwait:0, clr_before:0, clr_with:1, mask:8'h08, prior:8'h01,
                    exp_status:8'h08, exp_edge:8'h08, exp_irq:1};
        vecs[5] = '{data:8'h08, nwait:0, clr_before:1, clr_with:0, mask:8'hFF, prior:8'h00,
                    exp_status:8'h08, exp_edge:8'h00, exp_irq:0};

        reset = 1'b1; enable = 1'b1; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        avm_readdata = 32'h0; edge_clear = 1'b0; irq_mask = 8'h00;
        tick(); tick();
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_valid", 32'(status_valid), 32'd0);
        chk("rst_edge", 32'(edge_capture), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_address", 32'(avm_address), 32'(ADDR));

        reset = 1'b0;
        n = 0;
        while (!avm_read && n < 50) begin
            tick();
            n++;
        end
        chk("first_read_edge", n, PP);

        for (int v = 0; v < 6; v++) begin
            irq_mask = vecs[v].mask;
            if (vecs[v].clr_before) begin
                edge_clear = 1'b1;
                tick();
                edge_clear = 1'b0;
                chk("edge_after_clear", 32'(edge_capture), 32'd0);
                tick();
                chk("irq_after_clear", 32'(irq), 32'd0);
            end
            chk("edge_prior", 32'(edge_capture), 32'(vecs[v].prior));
            poll(vecs[v].data, vecs[v].nwait, vecs[v].clr_with, vecs[v].exp_status);
            chk("edge_capture", 32'(edge_capture), 32'(vecs[v].exp_edge));
            tick();
            chk("irq", 32'(irq), 32'(vecs[v].exp_irq));
        end

        // Timeout: accepted read, no data for TO cycles.
        wait_read();
        tick();
        flag = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            flag = flag | timeout_err;
        end
        chk("timeout_early", 32'(flag), 32'd0);
        tick();
        chk("timeout_err", 32'(timeout_err), 32'd1);
        chk("timeout_status", 32'(status), 32'h08);
        avm_readdata = 32'hFF; avm_readdatavalid = 1'b1;
        tick();
        avm_readdatavalid = 1'b0;
        chk("late_rdv_status", 32'(status), 32'h08);
        chk("late_rdv_edge", 32'(edge_capture), 32'd0);
        n = 1;
        while (!avm_read && n < 50) begin
            tick();
            n++;
        end
        chk("repoll_gap", n, PP);
        poll(8'h08, 0, 1'b0, 8'h08);
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        edge_clear = 1'b1;
        tick();
        edge_clear = 1'b0;
        chk("timeout_cleared", 32'(timeout_err), 32'd0);

        // Enable dropped during WAIT: transaction still completes.
        irq_mask = 8'hFF;
        wait_read();
        tick();
        enable = 1'b0;
        avm_readdata = 32'h0C; avm_readdatavalid = 1'b1;
        tick();
        avm_readdatavalid = 1'b0;
        chk("disabled_status", 32'(status), 32'h0C);
        chk("disabled_edge", 32'(edge_capture), 32'h04);
        flag = 1'b0;
        repeat (20) begin
            tick();
            flag = flag | avm_read;
        end
        chk("no_read_disabled", 32'(flag), 32'd0);
        enable = 1'b1;
        n = 0;
        while (!avm_read && n < 50) begin
            tick();
            n++;
        end
        chk("resume_gap", n, PP);

        // Reset asserted in WAIT, stray strobe after release.
        tick();
        chk("irq_before_reset", 32'(irq), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_read", 32'(avm_read), 32'd0);
        chk("mid_rst_status", 32'(status), 32'd0);
        chk("mid_rst_valid", 32'(status_valid), 32'd0);
        chk("mid_rst_edge", 32'(edge_capture), 32'd0);
        chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        tick();
        reset = 1'b0;
        avm_readdata = 32'h77; avm_readdatavalid = 1'b1;
        tick();
        avm_readdatavalid = 1'b0;
        chk("post_rst_status", 32'(status), 32'd0);
        chk("post_rst_valid", 32'(status_valid), 32'd0);
        chk("post_rst_read", 32'(avm_read), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
